// File: rtl/xor_vector_checker.sv
// On-chip self-test for a two-input XOR gate: sweeps the four input vectors,
// samples the gate output after a settle time and counts mismatches.
module xor_vector_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int PASSES        = 1,
  parameter int ERR_W         = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             F_in,
  output logic             A_out,
  output logic             B_out,
  output logic             Busy,
  output logic             Done,
  output logic             Pass,
  output logic [ERR_W-1:0] ErrorCnt,
  output logic [1:0]       FailVec
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [PW-1:0] PASS_LAST   = PW'(PASSES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [1:0]       vec, vec_nxt;
  logic [PW-1:0]    pass_cnt, pass_cnt_nxt;
  logic [SW-1:0]    settle_cnt, settle_nxt;
  logic             a_nxt, b_nxt, busy_nxt, done_nxt, pass_nxt;
  logic [ERR_W-1:0] err_nxt, err_inc;
  logic [1:0]       fail_nxt;
  logic             sample, mismatch, last_sample;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_nxt    = state;
    vec_nxt      = vec;
    pass_cnt_nxt = pass_cnt;
    settle_nxt   = settle_cnt;
    a_nxt        = A_out;
    b_nxt        = B_out;
    busy_nxt     = Busy;
    done_nxt     = Done;
    pass_nxt     = Pass;
    err_nxt      = ErrorCnt;
    fail_nxt     = FailVec;

    sample      = (state == RUN) && (settle_cnt == SETTLE_LAST);
    mismatch    = (F_in != (vec[0] ^ vec[1]));
    last_sample = (vec == 2'd3) && (pass_cnt == PASS_LAST);
    err_inc     = (ErrorCnt == {ERR_W{1'b1}}) ? ErrorCnt : ErrorCnt + ERR_W'(1);

    case (state)
      IDLE, DONE: begin
        if (Start) begin
          state_nxt    = RUN;
          busy_nxt     = 1'b1;
          done_nxt     = 1'b0;
          pass_nxt     = 1'b0;
          err_nxt      = '0;
          fail_nxt     = 2'd0;
          vec_nxt      = 2'd0;
          pass_cnt_nxt = '0;
          settle_nxt   = '0;
          a_nxt        = 1'b0;
          b_nxt        = 1'b0;
        end
      end
      RUN: begin
        settle_nxt = settle_cnt + SW'(1);
        if (sample) begin
          settle_nxt = '0;
          if (mismatch) begin
            err_nxt = err_inc;
            if (ErrorCnt == '0) begin
              fail_nxt = vec;
            end
          end
          if (last_sample) begin
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            a_nxt     = 1'b0;
            b_nxt     = 1'b0;
            pass_nxt  = (err_nxt == '0);
          end else begin
            vec_nxt = vec + 2'd1;
            if (vec == 2'd3) begin
              pass_cnt_nxt = pass_cnt + PW'(1);
            end
            a_nxt = vec_nxt[0];
            b_nxt = vec_nxt[1];
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers, cleared immediately when reset is asserted.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      vec        <= 2'd0;
      pass_cnt   <= '0;
      settle_cnt <= '0;
      A_out      <= 1'b0;
      B_out      <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Pass       <= 1'b0;
      ErrorCnt   <= '0;
      FailVec    <= 2'd0;
    end else begin
      state      <= state_nxt;
      vec        <= vec_nxt;
      pass_cnt   <= pass_cnt_nxt;
      settle_cnt <= settle_nxt;
      A_out      <= a_nxt;
      B_out      <= b_nxt;
      Busy       <= busy_nxt;
      Done       <= done_nxt;
      Pass       <= pass_nxt;
      ErrorCnt   <= err_nxt;
      FailVec    <= fail_nxt;
    end
  end

endmodule

// File: tb/tb_xor_vector_checker.sv
// Directed bench for xor_vector_checker: four instances cover default settings,
// two passes, a saturating 3-bit counter and single-cycle settling.
module tb_xor_vector_checker;

  logic Clk = 1'b0;
  logic Reset_n = 1'b1;
  int   total = 0;
  int   bad = 0;

  // default instance
  logic       start_def = 1'b0, f_def;
  logic [1:0] mode_def = 2'd0;
  logic       a_def, b_def, busy_def, done_def, pass_def;
  logic [7:0] err_def;
  logic [1:0] fv_def;

  // two passes, inverted gate
  logic       start_p2 = 1'b0, f_p2;
  logic       a_p2, b_p2, busy_p2, done_p2, pass_p2;
  logic [7:0] err_p2;
  logic [1:0] fv_p2;

  // 3-bit error counter, four passes, inverted gate
  logic       start_sat = 1'b0, f_sat;
  logic       a_sat, b_sat, busy_sat, done_sat, pass_sat;
  logic [2:0] err_sat;
  logic [1:0] fv_sat;

  // single-cycle settle, correct gate with glitches between edges
  logic       start_s1 = 1'b0, f_s1, glitch = 1'b0;
  logic       a_s1, b_s1, busy_s1, done_s1, pass_s1;
  logic [7:0] err_s1;
  logic [1:0] fv_s1;

  always #5 Clk = ~Clk;

  assign f_def = (mode_def == 2'd0) ? (a_def ^ b_def) :
                 (mode_def == 2'd1) ? 1'b0 : ~(a_def ^ b_def);
  assign f_p2  = ~(a_p2 ^ b_p2);
  assign f_sat = ~(a_sat ^ b_sat);
  assign f_s1  = a_s1 ^ b_s1 ^ glitch;

  xor_vector_checker u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(start_def), .F_in(f_def),
    .A_out(a_def), .B_out(b_def), .Busy(busy_def), .Done(done_def),
    .Pass(pass_def), .ErrorCnt(err_def), .FailVec(fv_def));

  xor_vector_checker #(.PASSES(2)) u_p2 (
    .Clk(Clk), .Reset_n(Reset_n), .Start(start_p2), .F_in(f_p2),
    .A_out(a_p2), .B_out(b_p2), .Busy(busy_p2), .Done(done_p2),
    .Pass(pass_p2), .ErrorCnt(err_p2), .FailVec(fv_p2));

  xor_vector_checker #(.ERR_W(3), .PASSES(4)) u_sat (
    .Clk(Clk), .Reset_n(Reset_n), .Start(start_sat), .F_in(f_sat),
    .A_out(a_sat), .B_out(b_sat), .Busy(busy_sat), .Done(done_sat),
    .Pass(pass_sat), .ErrorCnt(err_sat), .FailVec(fv_sat));

  xor_vector_checker #(.SETTLE_CYCLES(1)) u_s1 (
    .Clk(Clk), .Reset_n(Reset_n), .Start(start_s1), .F_in(f_s1),
    .A_out(a_s1), .B_out(b_s1), .Busy(busy_s1), .Done(done_s1),
    .Pass(pass_s1), .ErrorCnt(err_s1), .FailVec(fv_s1));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Selects the gate behaviour of the default instance and pulses Start across one edge (E0).
  task automatic applyStimulus(input logic [1:0] mode);
    mode_def  = mode;
    start_def = 1'b1;
    @(posedge Clk);
    #1;
    start_def = 1'b0;
  endtask

  initial begin
    int v;
    // reset state
    #2 Reset_n = 1'b0;
    #1;
    checkOutput("rst A", a_def, 0);
    checkOutput("rst B", b_def, 0);
    checkOutput("rst busy", busy_def, 0);
    checkOutput("rst done", done_def, 0);
    checkOutput("rst pass", pass_def, 0);
    checkOutput("rst err", err_def, 0);
    checkOutput("rst failvec", fv_def, 0);
    @(posedge Clk);
    #3 Reset_n = 1'b1;
    waitCycles(1);
    checkOutput("idle after release", busy_def, 0);

    // 1: correct gate, sequence and timing
    applyStimulus(2'd0);
    for (int k = 0; k <= 8; k++) begin
      checkOutput($sformatf("s1 busy k=%0d", k), busy_def, (k < 8) ? 1 : 0);
      checkOutput($sformatf("s1 done k=%0d", k), done_def, (k == 8) ? 1 : 0);
      v = k / 2;
      checkOutput($sformatf("s1 A k=%0d", k), a_def, (k < 8) ? (v & 1) : 0);
      checkOutput($sformatf("s1 B k=%0d", k), b_def, (k < 8) ? ((v >> 1) & 1) : 0);
      checkOutput($sformatf("s1 pass k=%0d", k), pass_def, (k == 8) ? 1 : 0);
      if (k < 8) waitCycles(1);
    end
    checkOutput("s1 err", err_def, 0);

    // 2: stuck-at-0 gate
    applyStimulus(2'd1);
    waitCycles(7);
    checkOutput("s2 done early", done_def, 0);
    waitCycles(1);
    checkOutput("s2 done", done_def, 1);
    checkOutput("s2 err", err_def, 2);
    checkOutput("s2 failvec", fv_def, 1);
    checkOutput("s2 pass", pass_def, 0);

    // 3: inverted gate, two passes and saturation
    start_p2 = 1'b1;
    waitCycles(1);
    start_p2 = 1'b0;
    waitCycles(15);
    checkOutput("s3 p2 done early", done_p2, 0);
    waitCycles(1);
    checkOutput("s3 p2 done", done_p2, 1);
    checkOutput("s3 p2 err", err_p2, 8);
    checkOutput("s3 p2 failvec", fv_p2, 0);
    checkOutput("s3 p2 pass", pass_p2, 0);
    start_sat = 1'b1;
    waitCycles(1);
    start_sat = 1'b0;
    waitCycles(32);
    checkOutput("s3 sat done", done_sat, 1);
    checkOutput("s3 sat err", err_sat, 7);
    checkOutput("s3 sat pass", pass_sat, 0);

    // 4a: Start during RUN is ignored
    applyStimulus(2'd0);
    waitCycles(2);
    start_def = 1'b1;
    waitCycles(1);
    start_def = 1'b0;
    checkOutput("s4 busy after restart try", busy_def, 1);
    checkOutput("s4 A at k3", a_def, 1);
    waitCycles(4);
    checkOutput("s4 done early", done_def, 0);
    waitCycles(1);
    checkOutput("s4 done", done_def, 1);
    checkOutput("s4 pass", pass_def, 1);
    checkOutput("s4 err", err_def, 0);

    // 4b: Start held high restarts right after DONE
    mode_def  = 2'd1;
    start_def = 1'b1;
    waitCycles(9);
    checkOutput("s4 held done", done_def, 1);
    checkOutput("s4 held err", err_def, 2);
    waitCycles(1);
    start_def = 1'b0;
    checkOutput("s4 restart busy", busy_def, 1);
    checkOutput("s4 restart done", done_def, 0);
    checkOutput("s4 restart err", err_def, 0);
    checkOutput("s4 restart pass", pass_def, 0);
    waitCycles(8);
    checkOutput("s4 second done", done_def, 1);
    checkOutput("s4 second err", err_def, 2);

    // 5: asynchronous reset mid-run
    applyStimulus(2'd1);
    waitCycles(5);
    checkOutput("s5 err before reset", err_def, 1);
    checkOutput("s5 B before reset", b_def, 1);
    #3 Reset_n = 1'b0;
    #1;
    checkOutput("s5 A", a_def, 0);
    checkOutput("s5 B", b_def, 0);
    checkOutput("s5 busy", busy_def, 0);
    checkOutput("s5 done", done_def, 0);
    checkOutput("s5 pass", pass_def, 0);
    checkOutput("s5 err", err_def, 0);
    checkOutput("s5 failvec", fv_def, 0);
    #1 Reset_n = 1'b1;
    waitCycles(1);
    checkOutput("s5 idle", busy_def, 0);
    applyStimulus(2'd1);
    waitCycles(8);
    checkOutput("s5 rerun done", done_def, 1);
    checkOutput("s5 rerun err", err_def, 2);
    checkOutput("s5 rerun failvec", fv_def, 1);

    // 6: single-cycle settle with glitches between edges
    start_s1 = 1'b1;
    waitCycles(1);
    start_s1 = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      checkOutput($sformatf("s6 done k=%0d", k), done_s1, (k == 4) ? 1 : 0);
      checkOutput($sformatf("s6 A k=%0d", k), a_s1, (k < 4) ? (k & 1) : 0);
      checkOutput($sformatf("s6 B k=%0d", k), b_s1, (k < 4) ? ((k >> 1) & 1) : 0);
      if (k < 4) begin
        #2 glitch = 1'b1;
        #2 glitch = 1'b0;
        @(posedge Clk);
        #1;
      end
    end
    checkOutput("s6 pass", pass_s1, 1);
    checkOutput("s6 err", err_s1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
